cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate cache controller between CPU load/store stage and datamem (byte-addressed, little-endian, 32-bit word port, combinational read, write on posedge).
Serves load hits in the request cycle. Fills a full line from datamem on a load miss, one word per access. Forwards every store to datamem, stalling the CPU meanwhile.

Parameters:
LINES, 8, number of cache lines; power of two; IDX_W = log2(LINES)
LINE_WORDS, 4, 32-bit words per line; power of two; OFF_W = log2(LINE_WORDS)
MEM_LATENCY, 1, cycles per datamem word access; >=1

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
readMem  in  1  CPU load request, held until stall=0
writeMem  in  1  CPU store request, held until stall=0
addr  in  32  CPU byte address; addr[1:0] ignored (word access)
writeData  in  32  CPU store data
readData  out  32  load data, valid when readMem & ~stall
stall  out  1  CPU must hold request and freeze
memAddr  out  32  datamem byte address
memWriteData  out  32  datamem write data
memWrite  out  1  datamem write enable, one-cycle pulse
memData  in  32  datamem combinational read data

Behaviour:
- Address split: word=addr[OFF_W+1:2], index=addr[OFF_W+IDX_W+1:OFF_W+2], tag=remaining upper bits.
- Storage: per line valid bit, tag, LINE_WORDS data words.
- Hit = valid[index] & tag match.
- FSM states: IDLE, FILL, WRITE. Request registers reqAddr/reqData are latched on acceptance in IDLE.
- IDLE, writeMem=1 (priority over readMem; both high is treated as a store): stall=1; latch request; go WRITE with waitCnt=0.
- IDLE, readMem=1 and hit: stall=0; readData=line word, combinational, same cycle.
- IDLE, readMem=1 and miss: stall=1; latch addr; go FILL with wordCnt=0, waitCnt=0.
- IDLE, no request: stall=0.
- FILL: stall=1; memAddr = {reqAddr line base, wordCnt, 2'b00}; waitCnt counts 0..MEM_LATENCY-1.
- FILL, at waitCnt=MEM_LATENCY-1: capture memData into word wordCnt; wordCnt++; waitCnt=0.
- FILL, after word LINE_WORDS-1 is captured: write tag, set valid, go IDLE. The held load then hits. Load-miss penalty = LINE_WORDS*MEM_LATENCY+1 stall cycles (5 at defaults).
- WRITE: memAddr=reqAddr with [1:0]=0; memWriteData=reqData.
- WRITE, waitCnt<MEM_LATENCY-1: stall=1, memWrite=0.
- WRITE, at waitCnt=MEM_LATENCY-1: memWrite=1, stall=0 (store retires on this edge); if reqAddr hits, update cached word on the same edge; go IDLE. Store misses do not allocate. Store penalty = MEM_LATENCY stall cycles.
- memAddr and memWriteData are 0 outside FILL and WRITE. memWrite is never asserted outside the final WRITE cycle.
- readData is 0 when not an IDLE hit.
- Reset: state=IDLE; all valid bits=0; wordCnt, waitCnt, reqAddr, reqData = 0.
- Outputs after reset with no request: stall=0, memWrite=0, memAddr=0, memWriteData=0, readData=0.
- Reset mid-FILL: the partial line stays invalid.
- Reset mid-WRITE: no memWrite pulse after the reset edge.
- Counter wrap: wordCnt wraps naturally at LINE_WORDS, but FILL exits on the last word.

Optional Feature:
CACHE_STATS_EN:
- Defined: adds outputs hitCount[31:0] and missCount[31:0], both 0 on reset.
- hitCount increments once per load accepted as a hit in IDLE.
- missCount increments once per IDLE->FILL transition.
- Stores are not counted. Both counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, datamem word 0x10=0xDEADBEEF, 0x14=0xCAFEF00D; load 0x10 after reset -> stall high 5 cycles, memAddr sequence 0x10,0x14,0x18,0x1C, then readData=0xDEADBEEF with stall=0; memWrite never pulses.
- Load 0x14 right after the fill -> hit, stall=0 in request cycle, readData=0xCAFEF00D.
- Store 0x18=0x12345678 (hit) -> stall 1 cycle, single memWrite pulse with memAddr=0x18, memWriteData=0x12345678; then load 0x18 -> no stall, 0x12345678.
- Store to 0x100 (miss) -> one memWrite pulse; then load 0x100 -> miss, 5 stall cycles (no allocate).
- Conflict: load 0x10, load 0x90 (same index, different tag), load 0x10 -> three misses, 5 stall cycles each.
- MEM_LATENCY=3, reset asserted during the 2nd FILL word, then load same address -> full 13-cycle miss. With CACHE_STATS_EN, a sequence of 2 hits and 3 misses -> hitCount=2, missCount=3.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// CPU-side and datamem-side signals of the cache controller.
// The slave modport is the controller; the master modport is the CPU/datamem side.
interface cache_ctrl_if;
   logic        readMem;
   logic        writeMem;
   logic [31:0] addr;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        stall;
   logic [31:0] memAddr;
   logic [31:0] memWriteData;
   logic        memWrite;
   logic [31:0] memData;

   modport slave (
      input  readMem, writeMem, addr, writeData, memData,
      output readData, stall, memAddr, memWriteData, memWrite
   );

   modport master (
      output readMem, writeMem, addr, writeData, memData,
      input  readData, stall, memAddr, memWriteData, memWrite
   );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Optional CACHE_STATS_EN adds saturating hitCount/missCount outputs.
module cache_ctrl #(
   parameter int LINES       = 8,
   parameter int LINE_WORDS  = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
`ifdef CACHE_STATS_EN
   output logic [31:0] hitCount,
   output logic [31:0] missCount,
`endif
   cache_ctrl_if.slave bus
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
   localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
   localparam logic [OFF_W-1:0]  WORD_LAST = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t              state_reg, state_next;
   logic [OFF_W-1:0]    word_cnt_reg, word_cnt_next;
   logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic [31:0]         req_addr_reg, req_addr_next;
   logic [31:0]         req_data_reg, req_data_next;

   // Data array is read combinationally so load hits return in the request cycle.
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [31:0]         data_mem [LINES*LINE_WORDS];
   logic [LINES-1:0]    valid_vec;

   logic [OFF_W-1:0]    cpu_word, req_word;
   logic [IDX_W-1:0]    cpu_idx, req_idx;
   logic [TAG_W-1:0]    cpu_tag, req_tag;
   logic                cpu_hit, req_hit;
   logic                wait_last;

   logic                fill_capture;
   logic                fill_done;
   logic                store_update;
   logic                hit_load;
   logic                accept_miss;

   assign cpu_word = bus.addr[OFF_W+1:2];
   assign cpu_idx  = bus.addr[OFF_W+IDX_W+1:OFF_W+2];
   assign cpu_tag  = bus.addr[31:OFF_W+IDX_W+2];
   assign req_word = req_addr_reg[OFF_W+1:2];
   assign req_idx  = req_addr_reg[OFF_W+IDX_W+1:OFF_W+2];
   assign req_tag  = req_addr_reg[31:OFF_W+IDX_W+2];

   assign cpu_hit   = valid_vec[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
   assign req_hit   = valid_vec[req_idx] && (tag_mem[req_idx] == req_tag);
   assign wait_last = (wait_cnt_reg == WAIT_LAST);

   // Valid bits only become set when the last word of a fill lands, so a
   // reset part-way through a fill leaves the line invalid.
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         logic line_valid_reg;
         always_ff @(posedge clk) begin
            if (reset)
               line_valid_reg <= 1'b0;
            else if (fill_done && (req_idx == IDX_W'(gi)))
               line_valid_reg <= 1'b1;
         end
         assign valid_vec[gi] = line_valid_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (fill_capture)
         data_mem[{req_idx, word_cnt_reg}] <= bus.memData;
      else if (store_update)
         data_mem[{req_idx, req_word}] <= req_data_reg;
      if (fill_done)
         tag_mem[req_idx] <= req_tag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         word_cnt_reg <= '0;
         wait_cnt_reg <= '0;
         req_addr_reg <= '0;
         req_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         word_cnt_reg <= word_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
         req_addr_reg <= req_addr_next;
         req_data_reg <= req_data_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      word_cnt_next    = word_cnt_reg;
      wait_cnt_next    = wait_cnt_reg;
      req_addr_next    = req_addr_reg;
      req_data_next    = req_data_reg;
      bus.stall        = 1'b0;
      bus.readData     = 32'h0;
      bus.memAddr      = 32'h0;
      bus.memWriteData = 32'h0;
      bus.memWrite     = 1'b0;
      fill_capture     = 1'b0;
      fill_done        = 1'b0;
      store_update     = 1'b0;
      hit_load         = 1'b0;
      accept_miss      = 1'b0;

      case (state_reg)
         IDLE: begin
            wait_cnt_next = '0;
            if (bus.writeMem) begin
               bus.stall     = 1'b1;
               req_addr_next = bus.addr;
               req_data_next = bus.writeData;
               state_next    = WRITE;
            end else if (bus.readMem) begin
               if (cpu_hit) begin
                  bus.readData = data_mem[{cpu_idx, cpu_word}];
                  hit_load     = 1'b1;
               end else begin
                  bus.stall     = 1'b1;
                  req_addr_next = bus.addr;
                  word_cnt_next = '0;
                  accept_miss   = 1'b1;
                  state_next    = FILL;
               end
            end
         end

         FILL: begin
            bus.stall   = 1'b1;
            bus.memAddr = {req_addr_reg[31:OFF_W+2], word_cnt_reg, 2'b00};
            if (wait_last) begin
               fill_capture  = 1'b1;
               wait_cnt_next = '0;
               word_cnt_next = word_cnt_reg + 1'b1;
               if (word_cnt_reg == WORD_LAST) begin
                  fill_done  = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end

         WRITE: begin
            bus.memAddr      = {req_addr_reg[31:2], 2'b00};
            bus.memWriteData = req_data_reg;
            if (wait_last) begin
               bus.memWrite  = 1'b1;
               store_update  = req_hit;
               wait_cnt_next = '0;
               state_next    = IDLE;
            end else begin
               bus.stall     = 1'b1;
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_reg;
   logic [31:0] miss_count_reg;
   logic        fill_return_reg;

   // The held load that completes a fill is already counted as a miss.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_reg   <= 32'h0;
         miss_count_reg  <= 32'h0;
         fill_return_reg <= 1'b0;
      end else begin
         fill_return_reg <= fill_done;
         if (hit_load && !fill_return_reg && (hit_count_reg != 32'hFFFF_FFFF))
            hit_count_reg <= hit_count_reg + 32'd1;
         if (accept_miss && (miss_count_reg != 32'hFFFF_FFFF))
            miss_count_reg <= miss_count_reg + 32'd1;
      end
   end

   assign hitCount  = hit_count_reg;
   assign missCount = miss_count_reg;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// each backed by a small combinational-read datamem model.
module tb_cache_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset1;
   logic reset3;
   logic dut_sel;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] seen_addr [16];
   int          seen_n;

   cache_ctrl_if b1 ();
   cache_ctrl_if b3 ();

`ifdef CACHE_STATS_EN
   logic [31:0] hit1, miss1, hit3, miss3;
`endif

   cache_ctrl #(.LINES(8), .LINE_WORDS(4), .MEM_LATENCY(1)) u_dut (
      .clk(clk),
      .reset(reset1),
`ifdef CACHE_STATS_EN
      .hitCount(hit1),
      .missCount(miss1),
`endif
      .bus(b1.slave)
   );

   cache_ctrl #(.LINES(8), .LINE_WORDS(4), .MEM_LATENCY(3)) u_dut3 (
      .clk(clk),
      .reset(reset3),
`ifdef CACHE_STATS_EN
      .hitCount(hit3),
      .missCount(miss3),
`endif
      .bus(b3.slave)
   );

   // Datamem model: untouched words return a fixed pattern, stored words return what was written.
   bit [31:0] mem1 [256];
   bit        wr1  [256];
   bit [31:0] mem3 [256];
   bit        wr3  [256];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hDEAD_BEEF;
         32'h14:  return 32'hCAFE_F00D;
         32'h20:  return 32'h2020_2020;
         32'h90:  return 32'h9090_9090;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign b1.memData = wr1[b1.memAddr[9:2]] ? mem1[b1.memAddr[9:2]] : init_word({b1.memAddr[31:2], 2'b00});
   assign b3.memData = wr3[b3.memAddr[9:2]] ? mem3[b3.memAddr[9:2]] : init_word({b3.memAddr[31:2], 2'b00});

   always @(posedge clk) begin
      if (b1.memWrite) begin
         mem1[b1.memAddr[9:2]] <= b1.memWriteData;
         wr1[b1.memAddr[9:2]]  <= 1'b1;
      end
      if (b3.memWrite) begin
         mem3[b3.memAddr[9:2]] <= b3.memWriteData;
         wr3[b3.memAddr[9:2]]  <= 1'b1;
      end
   end

   logic        s_stall, s_memWrite;
   logic [31:0] s_readData, s_memAddr, s_memWriteData;
   assign s_stall        = dut_sel ? b3.stall        : b1.stall;
   assign s_memWrite     = dut_sel ? b3.memWrite     : b1.memWrite;
   assign s_readData     = dut_sel ? b3.readData     : b1.readData;
   assign s_memAddr      = dut_sel ? b3.memAddr      : b1.memAddr;
   assign s_memWriteData = dut_sel ? b3.memWriteData : b1.memWriteData;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      if (dut_sel) begin
         b3.readMem = rd; b3.writeMem = wr; b3.addr = a; b3.writeData = d;
      end else begin
         b1.readMem = rd; b1.writeMem = wr; b1.addr = a; b1.writeData = d;
      end
   endtask

   // Called just after a posedge; returns just after a posedge with the request dropped.
   task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                          input int exp_stalls);
      int          stalls = 0;
      int          cyc    = 0;
      int          pulses = 0;
      logic        done   = 1'b0;
      logic [31:0] rd     = 32'h0;
      seen_n = 0;
      set_req(1'b1, 1'b0, a, 32'h0);
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (s_memWrite) pulses++;
         if (s_stall) begin
            stalls++;
            if (seen_n < 16) begin
               seen_addr[seen_n] = s_memAddr;
               seen_n++;
            end
            @(posedge clk); #1;
         end else begin
            done = 1'b1;
            rd   = s_readData;
         end
      end
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      $display("load  dut=%0d addr=%h data=%h stalls=%0d", dut_sel, a, rd, stalls);
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      check_eq({tag, "_data"}, rd, exp_data);
      check_eq({tag, "_nowrite"}, 32'(pulses), 32'd0);
   endtask

   task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic both, input int exp_stalls);
      int          stalls = 0;
      int          cyc    = 0;
      int          pulses = 0;
      logic        done   = 1'b0;
      logic [31:0] pa     = 32'h0;
      logic [31:0] pd     = 32'h0;
      set_req(both, 1'b1, a, d);
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (s_memWrite) begin
            pulses++;
            pa = s_memAddr;
            pd = s_memWriteData;
         end
         if (s_stall) begin
            stalls++;
            @(posedge clk); #1;
         end else begin
            done = 1'b1;
         end
      end
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      if (s_memWrite) pulses++;
      @(posedge clk); #1;
      $display("store dut=%0d addr=%h data=%h stalls=%0d pulses=%0d", dut_sel, a, d, stalls, pulses);
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
      check_eq({tag, "_maddr"}, pa, a);
      check_eq({tag, "_mdata"}, pd, d);
   endtask

   initial begin
      logic found;
      int   p;
      reset1  = 1'b1;
      reset3  = 1'b1;
      dut_sel = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      dut_sel = 1'b0;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset1 = 1'b0;
      reset3 = 1'b0;

      @(negedge clk);
      check_eq("rst_stall", 32'(s_stall), 32'd0);
      check_eq("rst_memwrite", 32'(s_memWrite), 32'd0);
      check_eq("rst_memaddr", s_memAddr, 32'h0);
      check_eq("rst_memwdata", s_memWriteData, 32'h0);
      check_eq("rst_readdata", s_readData, 32'h0);
      @(posedge clk); #1;

      do_load("miss_10", 32'h10, 32'hDEAD_BEEF, 5);
      check_eq("fill_idle_addr", seen_addr[0], 32'h0);
      check_eq("fill_addr0", seen_addr[1], 32'h10);
      check_eq("fill_addr1", seen_addr[2], 32'h14);
      check_eq("fill_addr2", seen_addr[3], 32'h18);
      check_eq("fill_addr3", seen_addr[4], 32'h1C);

      do_load("hit_14", 32'h14, 32'hCAFE_F00D, 0);
      do_store("st_hit_18", 32'h18, 32'h1234_5678, 1'b0, 1);
      do_load("hit_18", 32'h18, 32'h1234_5678, 0);
      do_store("st_miss_100", 32'h100, 32'hAABB_CCDD, 1'b0, 1);
      do_load("miss_100", 32'h100, 32'hAABB_CCDD, 5);

      // Conflict pair 0x10/0x90 shares index 1 with different tags.
      reset1 = 1'b1;
      @(posedge clk); #1;
      reset1 = 1'b0;
      do_load("conf_a", 32'h10, 32'hDEAD_BEEF, 5);
      do_load("conf_b", 32'h90, 32'h9090_9090, 5);
      do_load("conf_c", 32'h10, 32'hDEAD_BEEF, 5);

      do_store("st_both_14", 32'h14, 32'h1111_2222, 1'b1, 1);
      do_load("hit_14b", 32'h14, 32'h1111_2222, 0);

      // MEM_LATENCY=3: reset while the second fill word is outstanding.
      dut_sel = 1'b1;
      set_req(1'b1, 1'b0, 32'h20, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (s_memAddr == 32'h24) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check_eq("rst_fill_reached", 32'(found), 32'd1);
      reset3 = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      reset3 = 1'b0;
      do_load("lat3_miss_20", 32'h20, 32'h2020_2020, 13);

      // Reset while a store is still waiting on datamem.
      set_req(1'b0, 1'b1, 32'h30, 32'h7777_8888);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset3 = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      p = 0;
      @(negedge clk);
      if (s_memWrite) p++;
      @(posedge clk); #1;
      reset3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (s_memWrite) p++;
      end
      @(posedge clk); #1;
      $display("store dut=1 addr=00000030 reset mid-write pulses=%0d", p);
      check_eq("rst_write_pulses", 32'(p), 32'd0);
      check_eq("rst_write_mem", 32'(wr3[12]), 32'd0);
      dut_sel = 1'b0;

`ifdef CACHE_STATS_EN
      reset1 = 1'b1;
      @(posedge clk); #1;
      reset1 = 1'b0;
      @(negedge clk);
      check_eq("stats_rst_hit", hit1, 32'd0);
      check_eq("stats_rst_miss", miss1, 32'd0);
      @(posedge clk); #1;
      do_load("st_m1", 32'h10, 32'hDEAD_BEEF, 5);
      do_load("st_h1", 32'h10, 32'hDEAD_BEEF, 0);
      do_load("st_h2", 32'h14, 32'h1111_2222, 0);
      do_load("st_m2", 32'h90, 32'h9090_9090, 5);
      do_load("st_m3", 32'h10, 32'hDEAD_BEEF, 5);
      @(negedge clk);
      check_eq("stats_hit", hit1, 32'd2);
      check_eq("stats_miss", miss1, 32'd3);
      @(posedge clk); #1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
